// File: rtl/exe_md_stage.sv
// Execute-stage multiply/divide unit with valid/allowin handshake and HI/LO results.
// Define EXE_MD_DIV_EN to build the restoring radix-2 divider. Without it, div/divu retire in one cycle with no HI/LO write.
module exe_md_stage #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 64,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_ClrStpJmp_in,
  input  logic              id_valid_in,
  output logic              exe_allowin_out,
  input  logic              mem_allowin_in,
  output logic              exe_valid_out,
  input  logic [2:0]        id_md_op_in,
  input  logic [DATA_W-1:0] id_src0_in,
  input  logic [DATA_W-1:0] id_src1_in,
  input  logic [TAG_W-1:0]  id_tag_in,
  output logic [TAG_W-1:0]  exe_tag_out,
  output logic [DATA_W-1:0] exe_hi_out,
  output logic [DATA_W-1:0] exe_lo_out,
  output logic              exe_hilo_we_out,
  output logic              exe_busy_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
`ifdef EXE_MD_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_r, capture, ready, hilo_en;
  logic [2:0]         op_r;
  logic [TAG_W-1:0]   tag_r;
  logic [DATA_W-1:0]  src0_r, src1_r;
  logic               in_mul, mul_sgn;
  logic signed [2*DATA_W-1:0] mul_a, mul_b, mul_prod;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic sgn);
    return (sgn && v[DATA_W-1]) ? -v : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign ready           = (state_q == S_DONE);
  assign exe_valid_out   = valid_r && ready;
  assign exe_allowin_out = !valid_r || (ready && mem_allowin_in);
  assign capture         = exe_allowin_out && id_valid_in && !wb_ClrStpJmp_in;
  assign exe_busy_out    = (state_q == S_MUL) || (state_q == S_DIV);
  assign exe_hilo_we_out = exe_valid_out && hilo_en;
  assign exe_tag_out     = tag_r;
  assign in_mul          = (id_md_op_in == OP_MULT) || (id_md_op_in == OP_MULTU);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_MUL, S_DIV: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE:  if (mem_allowin_in) state_d = S_IDLE;
      default: ;
    endcase
    if (capture) begin
      state_d = S_DONE;
      if (in_mul && MUL_LAT > 1) begin
        state_d = S_MUL;
        cnt_d   = CNT_W'(MUL_LAT - 2);
      end
`ifdef EXE_MD_DIV_EN
      // A zero divisor skips the iteration and retires with the fixed result.
      else if ((id_md_op_in == OP_DIV || id_md_op_in == OP_DIVU) && id_src1_in != '0) begin
        state_d = S_DIV;
        cnt_d   = CNT_W'(DATA_W - 1);
      end
`endif
    end
    if (wb_ClrStpJmp_in) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_r <= 1'b0;
      op_r    <= '0;
      tag_r   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wb_ClrStpJmp_in)                    valid_r <= 1'b0;
      else if (capture)                       valid_r <= 1'b1;
      else if (exe_valid_out && mem_allowin_in) valid_r <= 1'b0;
      if (capture) begin
        op_r  <= id_md_op_in;
        tag_r <= id_tag_in;
      end
    end
  end

  // ---- p0: operand capture ----
  always_ff @(posedge clk) begin
    if (capture) begin
      src0_r <= id_src0_in;
      src1_r <= id_src1_in;
    end
  end

  // ---- p1: multiply, held across the MUL_LAT window ----
  assign mul_sgn  = (op_r == OP_MULT);
  assign mul_a    = {{DATA_W{mul_sgn & src0_r[DATA_W-1]}}, src0_r};
  assign mul_b    = {{DATA_W{mul_sgn & src1_r[DATA_W-1]}}, src1_r};
  assign mul_prod = mul_a * mul_b;

`ifdef EXE_MD_DIV_EN
  // ---- p1: restoring divide on magnitudes, signs restored at the output ----
  logic [DATA_W-1:0] quo_r, rem_r, dvs_r;
  logic              neg_q_r, neg_r_r, div_sgn_in;
  logic [DATA_W:0]   rem_shift, rem_trial;

  assign div_sgn_in = (id_md_op_in == OP_DIV);
  assign rem_shift  = {rem_r, quo_r[DATA_W-1]};
  assign rem_trial  = rem_shift - {1'b0, dvs_r};

  always_ff @(posedge clk) begin
    if (capture) begin
      quo_r   <= abs_val(id_src0_in, div_sgn_in);
      dvs_r   <= abs_val(id_src1_in, div_sgn_in);
      rem_r   <= '0;
      neg_q_r <= div_sgn_in & (id_src0_in[DATA_W-1] ^ id_src1_in[DATA_W-1]);
      neg_r_r <= div_sgn_in & id_src0_in[DATA_W-1];
    end else if (state_q == S_DIV) begin
      rem_r <= rem_trial[DATA_W] ? rem_shift[DATA_W-1:0] : rem_trial[DATA_W-1:0];
      quo_r <= {quo_r[DATA_W-2:0], ~rem_trial[DATA_W]};
    end
  end
`endif

  // ---- p2: HI/LO result select ----
  always_comb begin
    exe_hi_out = '0;
    exe_lo_out = '0;
    hilo_en    = 1'b0;
    case (op_r)
      OP_MULT, OP_MULTU: begin
        {exe_hi_out, exe_lo_out} = mul_prod;
        hilo_en = 1'b1;
      end
`ifdef EXE_MD_DIV_EN
      OP_DIV, OP_DIVU: begin
        hilo_en = 1'b1;
        if (src1_r == '0) begin
          exe_hi_out = src0_r;
          exe_lo_out = '1;
        end else begin
          exe_hi_out = apply_sign(rem_r, neg_r_r);
          exe_lo_out = apply_sign(quo_r, neg_q_r);
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exe_md_stage.sv
// Directed-vector bench for exe_md_stage (DATA_W=32, MUL_LAT=2); divider cases run when EXE_MD_DIV_EN is defined.
module tb_exe_md_stage;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 64;
  localparam int MUL_LAT = 2;

  logic              clk = 1'b0;
  logic              rst, flush, id_valid, mem_allowin;
  logic              allowin, valid, hilo_we, busy;
  logic [2:0]        op;
  logic [DATA_W-1:0] src0, src1, hi, lo;
  logic [TAG_W-1:0]  tag_in, tag_out;

  int n_tests = 0;
  int n_fail  = 0;

  exe_md_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .wb_ClrStpJmp_in(flush), .id_valid_in(id_valid),
    .exe_allowin_out(allowin), .mem_allowin_in(mem_allowin), .exe_valid_out(valid),
    .id_md_op_in(op), .id_src0_in(src0), .id_src1_in(src1), .id_tag_in(tag_in),
    .exe_tag_out(tag_out), .exe_hi_out(hi), .exe_lo_out(lo),
    .exe_hilo_we_out(hilo_we), .exe_busy_out(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] t);
    op = o; src0 = a; src1 = b; tag_in = t; id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
  endtask

`ifdef EXE_MD_DIV_EN
  task automatic wait_valid(output int cyc, output int busy_cnt);
    cyc = 1;
    busy_cnt = 0;
    while (!valid && cyc < 60) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
  endtask
  int cyc, bcnt;
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; mem_allowin = 1'b1;
    op = '0; src0 = '0; src1 = '0; tag_in = '0;
    tick();
    tick();
    check("rst_valid",   valid,   0);
    check("rst_allowin", allowin, 1);
    check("rst_busy",    busy,    0);
    check("rst_we",      hilo_we, 0);
    check("rst_hi",      hi,      0);
    check("rst_lo",      lo,      0);
    check("rst_tag",     tag_out, 0);
    rst = 1'b0;
    tick();

    // multu max*max
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1111);
    check("multu_c1_valid",   valid,   0);
    check("multu_c1_busy",    busy,    1);
    check("multu_c1_allowin", allowin, 0);
    tick();
    check("multu_c2_valid", valid,   1);
    check("multu_hi",       hi,      32'hFFFF_FFFE);
    check("multu_lo",       lo,      32'h0000_0001);
    check("multu_we",       hilo_we, 1);
    check("multu_busy",     busy,    0);
    check("multu_tag",      tag_out, 64'h1111);
    tick();
    check("multu_drain", valid, 0);

    // signed mult -3*5 and MIN*MIN, unsigned 0x80000000*2
    issue(3'd1, 32'hFFFF_FFFD, 32'd5, 64'h2222);
    tick();
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);
    tick();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 64'h3333);
    tick();
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'h0000_0000);
    tick();
    issue(3'd2, 32'h8000_0000, 32'd2, 64'h3434);
    tick();
    check("multu_carry_hi", hi, 32'h0000_0001);
    check("multu_carry_lo", lo, 32'h0000_0000);
    tick();

    // backpressure: result held, then released with a same-cycle new op
    mem_allowin = 1'b0;
    issue(3'd1, 32'd7, 32'd6, 64'hAAAA);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_valid",   valid,   1);
      check("hold_lo",      lo,      32'd42);
      check("hold_hi",      hi,      32'd0);
      check("hold_tag",     tag_out, 64'hAAAA);
      check("hold_allowin", allowin, 0);
      tick();
    end
    mem_allowin = 1'b1;
    op = 3'd2; src0 = 32'd3; src1 = 32'd4; tag_in = 64'hBBBB; id_valid = 1'b1;
    #1;
    check("release_allowin", allowin, 1);
    tick();
    id_valid = 1'b0;
    check("release_c1_valid", valid,   0);
    check("release_c1_tag",   tag_out, 64'hBBBB);
    tick();
    check("release_c2_valid", valid, 1);
    check("release_c2_lo",    lo,    32'd12);
    tick();

    // op none (0) and reserved (6): ready the following cycle, no HI/LO write
    issue(3'd0, 32'd1, 32'd2, 64'hCCCC);
    check("none_valid", valid,   1);
    check("none_we",    hilo_we, 0);
    check("none_busy",  busy,    0);
    check("none_lo",    lo,      0);
    check("none_tag",   tag_out, 64'hCCCC);
    tick();
    issue(3'd6, 32'd1, 32'd2, 64'hC6C6);
    check("op6_valid", valid,   1);
    check("op6_we",    hilo_we, 0);
    tick();

`ifndef EXE_MD_DIV_EN
    issue(3'd4, 32'd9, 32'd3, 64'hDDDD);
    check("nodiv_valid", valid,   1);
    check("nodiv_we",    hilo_we, 0);
    check("nodiv_hi",    hi,      0);
    check("nodiv_lo",    lo,      0);
    check("nodiv_busy",  busy,    0);
    tick();
`else
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 64'hD1D1);
    wait_valid(cyc, bcnt);
    check("div_valid",   valid,   1);
    check("div_latency", cyc,     33);
    check("div_busy",    bcnt,    32);
    check("div_lo",      lo,      32'hFFFF_FFFD);
    check("div_hi",      hi,      32'hFFFF_FFFF);
    check("div_we",      hilo_we, 1);
    tick();
    issue(3'd4, 32'd5, 32'd0, 64'hD2D2);
    check("divz_valid", valid, 1);
    check("divz_lo",    lo,    32'hFFFF_FFFF);
    check("divz_hi",    hi,    32'd5);
    tick();
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'hD3D3);
    wait_valid(cyc, bcnt);
    check("divmin_valid", valid, 1);
    check("divmin_lo",    lo,    32'h8000_0000);
    check("divmin_hi",    hi,    32'd0);
    tick();
    issue(3'd4, 32'd100, 32'd7, 64'hD4D4);
    repeat (9) tick();
    check("divflush_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("divflush_busy",    busy,    0);
    check("divflush_valid",   valid,   0);
    check("divflush_allowin", allowin, 1);
    check("divflush_we",      hilo_we, 0);
    tick();
`endif

    // flush during MUL
    issue(3'd2, 32'd2, 32'd3, 64'hEEEE);
    check("mflush_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("mflush_busy",    busy,    0);
    check("mflush_valid",   valid,   0);
    check("mflush_allowin", allowin, 1);
    check("mflush_we",      hilo_we, 0);
    tick();
    check("mflush_stays", valid, 0);

    // flush drops a simultaneous issue
    flush = 1'b1;
    issue(3'd0, 32'd1, 32'd1, 64'hF0F0);
    flush = 1'b0;
    check("fcap_valid", valid, 0);
    check("fcap_busy",  busy,  0);
    tick();
    check("fcap_later", valid, 0);

    // reset aborts an in-flight multiply
    issue(3'd2, 32'd9, 32'd9, 64'hABCD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy",    busy,    0);
    check("rstmid_valid",   valid,   0);
    check("rstmid_allowin", allowin, 1);
    check("rstmid_tag",     tag_out, 0);
    check("rstmid_lo",      lo,      0);
    tick();
    check("rstmid_later", valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
